sample_stream_packer: RTL and testbench

//  Parametrised single-clock capture buffer and byte serialiser for timetag samples.
//  - Accepts SAMPLE_W-bit words from the acquisition logic and stores them in an internal FIFO.
//  - Tags the first word accepted after any drop with a lost flag.
//  - Emits each word MSB-byte-first on an 8-bit rdy/ack stream toward the host-side reply path.
//  - Generalises the fixed 48-bit FIFO + multiplexer pairing in width, depth and loss reporting.

---
 rtl/sample_stream_packer_if.sv | 27 ++
 rtl/sample_stream_packer.sv | 169 ++++++++++++++++
 tb/tb_sample_stream_packer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_stream_packer_if.sv
// Sample-side, byte-stream and status signals of sample_stream_packer.
// slave is the packer's own view; master is the view of whatever drives it.
interface sample_stream_packer_if #(
    parameter int SAMPLE_W   = 48,
    parameter int DEPTH_LOG2 = 9,
    parameter int LOST_W     = 16
) ();
    logic                  flush;
    logic                  sample_rdy;
    logic [SAMPLE_W-2:0]   sample;
    logic                  data_rdy;
    logic [7:0]            data;
    logic                  data_ack;
    logic [DEPTH_LOG2:0]   fifo_level;
    logic [LOST_W-1:0]     lost_count;
    logic                  lost_clr;

    modport slave (
        input  flush, sample_rdy, sample, data_ack, lost_clr,
        output data_rdy, data, fifo_level, lost_count
    );

    modport master (
        output flush, sample_rdy, sample, data_ack, lost_clr,
        input  data_rdy, data, fifo_level, lost_count
    );
endinterface

// File: rtl/sample_stream_packer.sv
// Timetag capture FIFO plus MSB-first byte serialiser with loss tagging.
// Define LOST_COUNT_EN to build the saturating dropped-sample counter.
module sample_stream_packer #(
    parameter int SAMPLE_W   = 48,
    parameter int DEPTH_LOG2 = 9,
    parameter int LOST_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    sample_stream_packer_if.slave bus
);
    localparam int NB    = SAMPLE_W / 8;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int IDX_W = $clog2(NB);

    typedef logic [DEPTH_LOG2:0] ptr_t;
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [SAMPLE_W-1:0] rd_data_q;

    ptr_t                wr_ptr_q, wr_ptr_d;
    ptr_t                rd_ptr_q, rd_ptr_d;
    logic                lost_flag_q, lost_flag_d;
    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic                data_rdy_q, data_rdy_d;

    logic full, empty, push, drop, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {DEPTH_LOG2{1'b0}}});
    assign push  = bus.sample_rdy & ~full & ~bus.flush;
    assign drop  = bus.sample_rdy &  full & ~bus.flush;

    // Write side: the lost flag marks only the first word stored after a run of drops.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        wr_ptr_d    = wr_ptr_q;
        lost_flag_d = lost_flag_q;
        if (bus.flush) begin
            lost_flag_d = 1'b0;
        end else if (push) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            lost_flag_d = 1'b0;
        end else if (drop) begin
            lost_flag_d = 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {lost_flag_q, bus.sample};
        end
        if (pop) begin
            rd_data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
        end
    end

    // Read FSM. data_rdy is registered, so SEND spends one cycle presenting before the first byte.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        data_rdy_d = data_rdy_q;
        rd_ptr_d   = rd_ptr_q;
        pop        = 1'b0;

        if (bus.flush) begin
            state_d    = IDLE;
            data_rdy_d = 1'b0;
            shift_d    = '0;
            byte_idx_d = '0;
            rd_ptr_d   = wr_ptr_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    shift_d    = rd_data_q;
                    byte_idx_d = '0;
                    state_d    = SEND;
                end
                SEND: begin
                    if (!data_rdy_q) begin
                        data_rdy_d = 1'b1;
                    end else if (bus.data_ack) begin
                        if (byte_idx_q != IDX_W'(NB - 1)) begin
                            shift_d    = shift_q << 8;
                            byte_idx_d = byte_idx_q + 1'b1;
                        end else begin
                            data_rdy_d = 1'b0;
                            if (!empty) begin
                                pop     = 1'b1;
                                state_d = LOAD;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            lost_flag_q <= 1'b0;
            state_q     <= IDLE;
            shift_q     <= '0;
            byte_idx_q  <= '0;
            data_rdy_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            lost_flag_q <= lost_flag_d;
            state_q     <= state_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
            data_rdy_q  <= data_rdy_d;
        end
    end

    assign bus.data_rdy   = data_rdy_q;
    assign bus.data       = shift_q[SAMPLE_W-1 -: 8];
    assign bus.fifo_level = wr_ptr_q - rd_ptr_q;

`ifdef LOST_COUNT_EN
    logic [LOST_W-1:0] lost_cnt_q, lost_cnt_d;

    // A clear coinciding with a drop leaves that drop counted.
    always_comb begin
        lost_cnt_d = lost_cnt_q;
        if (bus.lost_clr) begin
            lost_cnt_d = drop ? LOST_W'(1) : '0;
        end else if (drop && !(&lost_cnt_q)) begin
            lost_cnt_d = lost_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lost_cnt_q <= '0;
        end else begin
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign bus.lost_count = lost_cnt_q;
`else
    logic unused_lost_clr;

    assign unused_lost_clr = bus.lost_clr;
    assign bus.lost_count  = '0;
`endif
endmodule

// File: tb/tb_sample_stream_packer.sv
// Scoreboard bench for sample_stream_packer: stimulus queues expected bytes,
// a negedge monitor pops and compares every acknowledged byte.
module tb_sample_stream_packer;
    localparam int SAMPLE_W   = 48;
    localparam int DEPTH_LOG2 = 9;
    localparam int LOST_W     = 8;
    localparam int DEPTH      = 2 ** DEPTH_LOG2;

`ifdef LOST_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    sample_stream_packer_if #(
        .SAMPLE_W(SAMPLE_W), .DEPTH_LOG2(DEPTH_LOG2), .LOST_W(LOST_W)
    ) dif ();

    sample_stream_packer #(
        .SAMPLE_W(SAMPLE_W), .DEPTH_LOG2(DEPTH_LOG2), .LOST_W(LOST_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];
    logic       hold_en  = 1'b1;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_b;
    int         ack_mode = 0;
    int         ack_cyc  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] lc(input int n);
        return CNT_EN ? 64'(n) : 64'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic [46:0] s);
        dif.sample_rdy = 1'b1;
        dif.sample     = s;
        step();
    endtask

    task automatic write_word(input logic [46:0] s, input logic flag);
        logic [47:0] w;
        w = {flag, s};
        for (int b = 0; b < 6; b++) exp_q.push_back(w[47-8*b -: 8]);
        drive_sample(s);
    endtask

    task automatic wait_rdy(input string name);
        int n = 0;
        while (dif.data_rdy !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check(name, 64'(dif.data_rdy), 64'd1);
    endtask

    task automatic wait_not_full(input string name);
        int n = 0;
        while (dif.fifo_level >= (DEPTH_LOG2+1)'(DEPTH) && n < 100) begin
            step();
            n++;
        end
        check(name, 64'(dif.fifo_level < (DEPTH_LOG2+1)'(DEPTH)), 64'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && dif.fifo_level == 0 && dif.data_rdy == 1'b0) && n < budget) begin
            step();
            n++;
        end
        check({name, "_queue"}, 64'(exp_q.size()), 64'd0);
        check({name, "_level"}, 64'(dif.fifo_level), 64'd0);
    endtask

    // Throttled acknowledge: one ack every fourth cycle while ack_mode == 1.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ack_mode == 1) begin
                dif.data_ack = (ack_cyc % 4 == 0);
                ack_cyc++;
            end
        end
    end

    // Monitor: stability of unacknowledged bytes and in-order delivery.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && hold_en) begin
                    check("hold_rdy", 64'(dif.data_rdy), 64'd1);
                    check("hold_data", 64'(dif.data), 64'(prev_data));
                end
                prev_hold = dif.data_rdy && !dif.data_ack && hold_en;
                prev_data = dif.data;
                if (dif.data_rdy && dif.data_ack) begin
                    check("byte_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        check("byte", 64'(dif.data), 64'(exp_b));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        dif.flush      = 1'b0;
        dif.sample_rdy = 1'b0;
        dif.sample     = '0;
        dif.data_ack   = 1'b0;
        dif.lost_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_rdy", 64'(dif.data_rdy), 64'd0);
        check("rst_data", 64'(dif.data), 64'd0);
        check("rst_level", 64'(dif.fifo_level), 64'd0);
        check("rst_lost", 64'(dif.lost_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("rel_data_rdy", 64'(dif.data_rdy), 64'd0);
        check("rel_level", 64'(dif.fifo_level), 64'd0);

        // 1: single word, ack held high, latency and six-byte burst
        dif.data_ack = 1'b1;
        write_word(47'h1234_5678_9ABC, 1'b0);
        dif.sample_rdy = 1'b0;
        check("lat_n0", 64'(dif.data_rdy), 64'd0);
        step(); check("lat_n1", 64'(dif.data_rdy), 64'd0);
        step(); check("lat_n2", 64'(dif.data_rdy), 64'd0);
        step(); check("lat_n3", 64'(dif.data_rdy), 64'd1);
        for (int i = 1; i < 6; i++) begin
            step();
            check("rdy_run", 64'(dif.data_rdy), 64'd1);
        end
        step(); check("rdy_gap", 64'(dif.data_rdy), 64'd0);
        wait_drain("t1_drain", 50);

        // 2: fill to full with no acks, then three drops and lost-flag tagging
        dif.data_ack = 1'b0;
        for (int i = 0; i <= DEPTH; i++) write_word(47'h0A0B_0000_0000 + 47'(i), 1'b0);
        check("level_full", 64'(dif.fifo_level), 64'(DEPTH));
        for (int i = 0; i < 3; i++) drive_sample(47'h7F7F_7F7F_7F7F);
        dif.sample_rdy = 1'b0;
        check("level_after_drop", 64'(dif.fifo_level), 64'(DEPTH));
        check("lost_three", 64'(dif.lost_count), lc(3));
        dif.data_ack = 1'b1;
        wait_not_full("t2_room_a");
        write_word(47'h0B00_0000_0001, 1'b1);
        dif.sample_rdy = 1'b0;
        wait_not_full("t2_room_b");
        write_word(47'h0C00_0000_0002, 1'b0);
        dif.sample_rdy = 1'b0;
        wait_drain("t2_drain", 6000);

        // 3: throttled acks, eight back-to-back words
        dif.data_ack = 1'b0;
        ack_mode = 1;
        for (int i = 0; i < 8; i++) write_word({7'(i + 1), 40'hC0_FFEE_0000 + 40'(i)}, 1'b0);
        dif.sample_rdy = 1'b0;
        wait_drain("t3_drain", 1000);
        ack_mode = 0;
        dif.data_ack = 1'b0;

        // 4: flush after two bytes of the first of six words
        for (int i = 0; i < 6; i++) write_word(47'h2100_0000_0000 + 47'(i), 1'b0);
        dif.sample_rdy = 1'b0;
        wait_rdy("t4_rdy");
        dif.data_ack = 1'b1;
        step();
        step();
        dif.data_ack = 1'b0;
        check("t4_level_queued", 64'(dif.fifo_level), 64'd5);
        hold_en = 1'b0;
        dif.flush = 1'b1;
        dif.sample_rdy = 1'b1;
        dif.sample = 47'h3333_3333_3333;
        step();
        dif.flush = 1'b0;
        dif.sample_rdy = 1'b0;
        exp_q.delete();
        check("flush_rdy", 64'(dif.data_rdy), 64'd0);
        check("flush_level", 64'(dif.fifo_level), 64'd0);
        check("flush_lost_kept", 64'(dif.lost_count), lc(3));
        hold_en = 1'b1;
        step();
        check("flush_idle", 64'(dif.data_rdy), 64'd0);
        dif.data_ack = 1'b1;
        write_word(47'h4455_6677_8899, 1'b0);
        dif.sample_rdy = 1'b0;
        wait_drain("t4_drain", 50);

        // 5: asynchronous reset in the middle of SEND
        dif.data_ack = 1'b0;
        for (int i = 0; i < 3; i++) write_word(47'h5500_0000_0000 + 47'(i), 1'b0);
        dif.sample_rdy = 1'b0;
        wait_rdy("t5_rdy");
        hold_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_rdy", 64'(dif.data_rdy), 64'd0);
        check("arst_level", 64'(dif.fifo_level), 64'd0);
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        hold_en = 1'b1;
        step();
        step();
        check("arst_no_stale", 64'(dif.data_rdy), 64'd0);
        check("arst_level_after", 64'(dif.fifo_level), 64'd0);
        check("arst_lost", 64'(dif.lost_count), 64'd0);

        // 6: counter saturation, clear coincident with a drop, flush keeps count
        for (int i = 0; i <= DEPTH; i++) drive_sample(47'h6600_0000_0000 + 47'(i));
        for (int i = 0; i < 300; i++) drive_sample(47'h6700_0000_0000 + 47'(i));
        dif.sample_rdy = 1'b0;
        check("lost_sat", 64'(dif.lost_count), lc(255));
        dif.lost_clr = 1'b1;
        drive_sample(47'h6800_0000_0000);
        dif.lost_clr = 1'b0;
        check("lost_clr_with_drop", 64'(dif.lost_count), lc(1));
        drive_sample(47'h6800_0000_0001);
        dif.sample_rdy = 1'b0;
        check("lost_after_clr", 64'(dif.lost_count), lc(2));
        hold_en = 1'b0;
        dif.flush = 1'b1;
        dif.sample_rdy = 1'b1;
        step();
        dif.flush = 1'b0;
        dif.sample_rdy = 1'b0;
        check("t6_flush_level", 64'(dif.fifo_level), 64'd0);
        check("t6_flush_lost", 64'(dif.lost_count), lc(2));
        hold_en = 1'b1;
        dif.lost_clr = 1'b1;
        step();
        dif.lost_clr = 1'b0;
        check("lost_clr", 64'(dif.lost_count), 64'd0);
        dif.data_ack = 1'b1;
        write_word(47'h7766_5544_3322, 1'b0);
        dif.sample_rdy = 1'b0;
        wait_drain("t6_drain", 50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
